// File: rtl/ram_1w_1rs_ext_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_1w_1rs_ext_if
// Description : Port bundle for ram_1w_1rs_ext. It carries the write port,
//               the read port, the clear request and the status outputs.
//               The master modport is the client side. The slave modport
//               is the RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_1w_1rs_ext_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32,
    parameter int MASK_WIDTH = 4
);
    logic                  wr_en;
    logic [MASK_WIDTH-1:0] wr_mask;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  clr_req;
    logic                  init_busy;
    logic [15:0]           collision_cnt;

    modport master (
        output wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, init_busy, collision_cnt
    );

    modport slave (
        input  wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, init_busy, collision_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ram_1w_1rs_ext.sv
`default_nettype none
// ============================================================================
// Module      : ram_1w_1rs_ext
// Description : Single-clock 1W1R synchronous RAM. Features:
//               - byte-lane (lane) write masks
//               - read-under-write policy: RDW_MODE 0 returns old data,
//                 RDW_MODE 1 returns the lane-merged new data
//               - READ_LATENCY of 1 or 2, qualified by rd_valid
//               - zero-fill sweep after reset and on clr_req
//               Optional feature macro: RAM_1W_1RS_EXT_COLLISION_CNT_EN
//               enables the saturating same-address collision counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1w_1rs_ext #(
    parameter int WORD_COUNT   = 1024,
    parameter int WORD_WIDTH   = 32,
    parameter int MASK_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ram_1w_1rs_ext_if.slave bus
);
    localparam int                    C_LANE      = WORD_WIDTH / MASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } seq_state_t;

    seq_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic                  r_init_busy;

    // The array has no reset; the sweep defines its contents.
    logic [WORD_WIDTH-1:0] r_mem [WORD_COUNT];

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_collision;
    logic [WORD_WIDTH-1:0] w_rd_word;

    logic [WORD_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    // Both ports are blocked for the whole sweep.
    assign w_wr_acc    = bus.wr_en & ~r_init_busy;
    assign w_rd_acc    = bus.rd_en & ~r_init_busy;
    assign w_collision = w_wr_acc & w_rd_acc & (bus.wr_addr == bus.rd_addr);

    // Clear sequencer: sweep every address once, then idle until clr_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_ptr   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
                    if (r_clr_ptr == C_LAST_ADDR) begin
                        r_state     <= ST_IDLE;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state     <= ST_CLEAR;
                        r_clr_ptr   <= '0;
                        r_init_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_clr_ptr   <= '0;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Array write: the sweep has priority; otherwise only enabled lanes change.
    always_ff @(posedge clk) begin
        if (r_init_busy) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (bus.wr_en) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (bus.wr_mask[i]) begin
                    r_mem[bus.wr_addr][i*C_LANE +: C_LANE] <= bus.wr_data[i*C_LANE +: C_LANE];
                end
            end
        end
    end

    // Read word with optional lane-wise bypass of a same-address write.
    always_comb begin
        w_rd_word = r_mem[bus.rd_addr];
        if ((RDW_MODE == 1) && w_collision) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (bus.wr_mask[i]) begin
                    w_rd_word[i*C_LANE +: C_LANE] = bus.wr_data[i*C_LANE +: C_LANE];
                end
            end
        end
    end

    // First read stage; data holds between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [WORD_WIDTH-1:0] r_s2_data;
        logic                  r_s2_valid;

        // Extra output register delays data and strobe together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_data  <= '0;
                r_s2_valid <= 1'b0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign bus.rd_data  = r_s2_data;
        assign bus.rd_valid = r_s2_valid;
    end else begin : g_lat1
        assign bus.rd_data  = r_s1_data;
        assign bus.rd_valid = r_s1_valid;
    end

    assign bus.init_busy = r_init_busy;

`ifdef RAM_1W_1RS_EXT_COLLISION_CNT_EN
    logic [15:0] r_collision_cnt;

    // Saturating collision counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision_cnt <= 16'd0;
        end else if (w_collision && (r_collision_cnt != 16'hFFFF)) begin
            r_collision_cnt <= r_collision_cnt + 16'd1;
        end
    end

    assign bus.collision_cnt = r_collision_cnt;
`else
    assign bus.collision_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
